// File: rtl/timer_reload_ctrl_if.sv
// Bus bundle for timer_reload_ctrl.
// The master drives the tick and the CPU write strobes.
// The slave (the counter block) returns the registered counter state.
interface timer_reload_ctrl_if #(
  parameter int WIDTH = 8
) ();
  logic             tick;
  logic             cnt_we;
  logic [WIDTH-1:0] cnt_wdata;
  logic             mod_we;
  logic [WIDTH-1:0] mod_wdata;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] modulo;
  logic             reloading;
  logic             irq;

  modport master (
    output tick, cnt_we, cnt_wdata, mod_we, mod_wdata,
    input  count, modulo, reloading, irq
  );

  modport slave (
    input  tick, cnt_we, cnt_wdata, mod_we, mod_wdata,
    output count, modulo, reloading, irq
  );
endinterface

// File: rtl/timer_reload_ctrl.sv
// Reloadable up-counter with delayed modulo reload and an overflow IRQ
// (DMG TIMA/TMA style).
//
// After an overflow the counter reads zero for RELOAD_DELAY cycles (WAIT).
// It then spends one LOAD cycle showing the modulo value, with irq and
// reloading both high.
//
// CPU writes race against that window as follows:
//  - A counter write in WAIT cancels the reload and the IRQ.
//  - A counter write in LOAD is dropped.
//  - A modulo write in LOAD also passes through to the counter.
module timer_reload_ctrl #(
  parameter int WIDTH        = 8,
  parameter int RELOAD_DELAY = 4
) (
  input  logic                clk,
  input  logic                reset,
  timer_reload_ctrl_if.slave  bus
);

  // Wide enough to hold RELOAD_DELAY-1, never narrower than one bit.
  localparam int DW = (RELOAD_DELAY > 1) ? $clog2(RELOAD_DELAY) : 1;
  localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
  localparam logic [DW-1:0]    DLY_INIT = DW'(RELOAD_DELAY - 1);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_LOAD = 2'd2
  } state_t;

  state_t           state_q,     state_d;
  logic [WIDTH-1:0] count_q,     count_d;
  logic [WIDTH-1:0] modulo_q,    modulo_d;
  logic [DW-1:0]    delay_q,     delay_d;
  logic             irq_q,       irq_d;
  logic             reloading_q, reloading_d;

  // Next-state logic for the counter, the modulo register and the reload window.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    modulo_d    = modulo_q;
    delay_d     = delay_q;
    irq_d       = 1'b0;
    reloading_d = 1'b0;

    // The modulo register accepts CPU writes in every state.
    if (bus.mod_we) begin
      modulo_d = bus.mod_wdata;
    end

    case (state_q)
      ST_RUN: begin
        if (bus.cnt_we) begin
          // A CPU write wins over a tick in the same cycle.
          count_d = bus.cnt_wdata;
        end else if (bus.tick) begin
          if (count_q == CNT_MAX) begin
            count_d = '0;
            delay_d = DLY_INIT;
            state_d = ST_WAIT;
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end
      end

      ST_WAIT: begin
        // Ticks are ignored here; the counter holds zero until the reload.
        if (bus.cnt_we) begin
          // A CPU write aborts the pending reload and its interrupt.
          count_d = bus.cnt_wdata;
          delay_d = '0;
          state_d = ST_RUN;
        end else if (delay_q == '0) begin
          // A modulo write on this same edge is used for the reload value.
          count_d     = bus.mod_we ? bus.mod_wdata : modulo_q;
          irq_d       = 1'b1;
          reloading_d = 1'b1;
          state_d     = ST_LOAD;
        end else begin
          delay_d = delay_q - DW'(1);
        end
      end

      ST_LOAD: begin
        // Counter writes and ticks are dropped.
        // A modulo write lands in the counter as well.
        if (bus.mod_we) begin
          count_d = bus.mod_wdata;
        end
        state_d = ST_RUN;
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State register; reset takes priority over every input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      count_q     <= '0;
      modulo_q    <= '0;
      delay_q     <= '0;
      irq_q       <= 1'b0;
      reloading_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      modulo_q    <= modulo_d;
      delay_q     <= delay_d;
      irq_q       <= irq_d;
      reloading_q <= reloading_d;
    end
  end

  assign bus.count     = count_q;
  assign bus.modulo    = modulo_q;
  assign bus.irq       = irq_q;
  assign bus.reloading = reloading_q;

endmodule

// File: tb/tb_timer_reload_ctrl.sv
// Directed bench for timer_reload_ctrl.
// Each stimulus cycle queues the outputs expected after the next edge.
// A monitor on the falling edge pops the queue and compares against the DUT.
module tb_timer_reload_ctrl;

  logic clk;
  logic reset;
  int   cyc_cnt;
  int   checks;
  int   errors;

  timer_reload_ctrl_if #(.WIDTH(8)) bus ();

  timer_reload_ctrl #(.WIDTH(8), .RELOAD_DELAY(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int         cyc;
    string      name;
    logic [7:0] count;
    logic [7:0] modulo;
    logic       irq;
    logic       rl;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Monitor: compare every queued expectation that is due in this cycle.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc_cnt) begin
      mon_e  = sb_q.pop_front();
      checks = checks + 1;
      if (mon_e.cyc != cyc_cnt || bus.count !== mon_e.count ||
          bus.modulo !== mon_e.modulo || bus.irq !== mon_e.irq ||
          bus.reloading !== mon_e.rl) begin
        errors = errors + 1;
        $display("FAIL %s cyc=%0d: got count=%h modulo=%h irq=%b reloading=%b, expected count=%h modulo=%h irq=%b reloading=%b",
                 mon_e.name, cyc_cnt, bus.count, bus.modulo, bus.irq, bus.reloading,
                 mon_e.count, mon_e.modulo, mon_e.irq, mon_e.rl);
      end else begin
        $display("ok   %s cyc=%0d: count=%h modulo=%h irq=%b reloading=%b",
                 mon_e.name, cyc_cnt, bus.count, bus.modulo, bus.irq, bus.reloading);
      end
    end
  end

  // Apply one cycle of inputs and queue the outputs expected after the edge.
  task automatic drive(input string nm, input logic r, input logic t,
                       input logic cwe, input logic [7:0] cd,
                       input logic mwe, input logic [7:0] md,
                       input logic [7:0] ec, input logic [7:0] em,
                       input logic ei, input logic erl);
    exp_t e;
    reset         = r;
    bus.tick      = t;
    bus.cnt_we    = cwe;
    bus.cnt_wdata = cd;
    bus.mod_we    = mwe;
    bus.mod_wdata = md;
    @(posedge clk);
    #1;
    e.cyc    = cyc_cnt;
    e.name   = nm;
    e.count  = ec;
    e.modulo = em;
    e.irq    = ei;
    e.rl     = erl;
    sb_q.push_back(e);
  endtask

  task automatic idle(input string nm, input logic [7:0] ec, input logic [7:0] em,
                      input logic ei, input logic erl);
    drive(nm, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, ec, em, ei, erl);
  endtask

  task automatic tick(input string nm, input logic [7:0] ec, input logic [7:0] em,
                      input logic ei, input logic erl);
    drive(nm, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, ec, em, ei, erl);
  endtask

  task automatic cwrite(input string nm, input logic [7:0] d, input logic [7:0] em);
    drive(nm, 1'b0, 1'b0, 1'b1, d, 1'b0, 8'h00, d, em, 1'b0, 1'b0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, limit 200000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    bus.tick      = 1'b0;
    bus.cnt_we    = 1'b0;
    bus.cnt_wdata = 8'h00;
    bus.mod_we    = 1'b0;
    bus.mod_wdata = 8'h00;

    // Reset state
    drive("rst0", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    drive("rst1", 1'b1, 1'b1, 1'b1, 8'h77, 1'b1, 8'h66, 8'h00, 8'h00, 1'b0, 1'b0);

    // Basic overflow and delayed reload; ticks in WAIT/LOAD ignored
    drive("t2_setup", 1'b0, 1'b0, 1'b1, 8'hFE, 1'b1, 8'h10, 8'hFE, 8'h10, 1'b0, 1'b0);
    tick("t2_ff",   8'hFF, 8'h10, 1'b0, 1'b0);
    tick("t2_ovf",  8'h00, 8'h10, 1'b0, 1'b0);
    tick("t2_w2",   8'h00, 8'h10, 1'b0, 1'b0);
    idle("t2_w3",   8'h00, 8'h10, 1'b0, 1'b0);
    tick("t2_w4",   8'h00, 8'h10, 1'b0, 1'b0);
    idle("t2_load", 8'h10, 8'h10, 1'b1, 1'b1);
    tick("t2_run",  8'h10, 8'h10, 1'b0, 1'b0);

    // Write beats tick in RUN
    drive("t6_wr_tick", 1'b0, 1'b1, 1'b1, 8'h20, 1'b0, 8'h00, 8'h20, 8'h10, 1'b0, 1'b0);
    tick("t6_tick", 8'h21, 8'h10, 1'b0, 1'b0);

    // Counter write in the 2nd WAIT cycle cancels reload and irq
    cwrite("t3_set", 8'hFF, 8'h10);
    tick("t3_ovf", 8'h00, 8'h10, 1'b0, 1'b0);
    idle("t3_w2",  8'h00, 8'h10, 1'b0, 1'b0);
    cwrite("t3_wr", 8'h55, 8'h10);
    tick("t3_tick", 8'h56, 8'h10, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) idle("t3_noirq", 8'h56, 8'h10, 1'b0, 1'b0);

    // Counter write during LOAD is dropped
    cwrite("t4_set", 8'hFF, 8'h10);
    tick("t4_ovf", 8'h00, 8'h10, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) idle("t4_wait", 8'h00, 8'h10, 1'b0, 1'b0);
    idle("t4_load", 8'h10, 8'h10, 1'b1, 1'b1);
    drive("t4_wr_load", 1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 8'h00, 8'h10, 8'h10, 1'b0, 1'b0);
    idle("t4_run", 8'h10, 8'h10, 1'b0, 1'b0);

    // Modulo write during LOAD passes through to count
    cwrite("t5a_set", 8'hFF, 8'h10);
    tick("t5a_ovf", 8'h00, 8'h10, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) idle("t5a_wait", 8'h00, 8'h10, 1'b0, 1'b0);
    idle("t5a_load", 8'h10, 8'h10, 1'b1, 1'b1);
    drive("t5a_modload", 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h80, 8'h80, 8'h80, 1'b0, 1'b0);
    idle("t5a_run", 8'h80, 8'h80, 1'b0, 1'b0);

    // Modulo write on the last WAIT cycle is used as the reload value
    cwrite("t5b_set", 8'hFF, 8'h80);
    tick("t5b_ovf", 8'h00, 8'h80, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) idle("t5b_wait", 8'h00, 8'h80, 1'b0, 1'b0);
    drive("t5b_load", 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h40, 8'h40, 8'h40, 1'b1, 1'b1);
    idle("t5b_run", 8'h40, 8'h40, 1'b0, 1'b0);

    // Reset in the middle of WAIT clears everything; no irq afterwards
    cwrite("t1_set", 8'hFF, 8'h40);
    tick("t1_ovf", 8'h00, 8'h40, 1'b0, 1'b0);
    idle("t1_w2",  8'h00, 8'h40, 1'b0, 1'b0);
    drive("t1_rst", 1'b1, 1'b1, 1'b1, 8'hAA, 1'b1, 8'h33, 8'h00, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) idle("t1_noirq", 8'h00, 8'h00, 1'b0, 1'b0);
    tick("t1_run", 8'h01, 8'h00, 1'b0, 1'b0);

    // Modulo 0xFF: the first tick after LOAD overflows again
    drive("ff_set", 1'b0, 1'b0, 1'b1, 8'hFF, 1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
    tick("ff_ovf1", 8'h00, 8'hFF, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) idle("ff_wait1", 8'h00, 8'hFF, 1'b0, 1'b0);
    idle("ff_load1", 8'hFF, 8'hFF, 1'b1, 1'b1);
    tick("ff_run",   8'hFF, 8'hFF, 1'b0, 1'b0);
    tick("ff_ovf2",  8'h00, 8'hFF, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) idle("ff_wait2", 8'h00, 8'hFF, 1'b0, 1'b0);
    idle("ff_load2", 8'hFF, 8'hFF, 1'b1, 1'b1);
    idle("ff_end",   8'hFF, 8'hFF, 1'b0, 1'b0);

    // Let the monitor drain, then make sure nothing was left unchecked.
    @(negedge clk);
    #1;
    checks = checks + 1;
    if (sb_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
